// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
//   Sequential radix-2 Booth multiplier. The control FSM, the A/Q/M registers
//   and the add/subtract step all live in this one N-bit core. An operation is
//   started with a start/done handshake and produces a 2N-bit two's-complement
//   product.
//
// Parameters
//   N             operand width in bits (N >= 2); the product is 2N bits
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   start         request, only looked at while idle
//   uns           (only with BOOTH_UNSIGNED_EN) treat operands as unsigned
//   multiplicand  M operand, N bits
//   multiplier    Q operand, N bits
//   busy          high while iterating
//   done          one-cycle pulse when the product has just been updated
//   product       registered 2N-bit result, held until the next completion
//
// Optional feature macro: BOOTH_UNSIGNED_EN adds the 'uns' input and an
// unsigned mode that runs one extra iteration on zero-extended operands.
// -----------------------------------------------------------------------------
module booth_mult_seq #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
`ifdef BOOTH_UNSIGNED_EN
   input  logic           uns,
`endif
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N + 2);
`ifdef BOOTH_UNSIGNED_EN
   localparam int QW = N + 1;
`else
   localparam int QW = N;
`endif

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [N:0]       a;
   logic [N:0]       m;
   logic [QW-1:0]    q;
   logic             q_1;
   logic [CW-1:0]    cnt;
`ifdef BOOTH_UNSIGNED_EN
   logic             uns_r;
`endif

   logic [N:0]       a_sum;
   logic [N:0]       a_next;
   logic [QW-1:0]    q_next;
   logic [2*N-1:0]   result;

   // State register. Reset is asynchronous and forces the FSM back to IDLE
   // from anywhere, which also abandons any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the status outputs. RUN ends on the iteration
   // where the counter is at 1, so exactly cnt-load iterations are done.
   // DONE always lasts a single cycle, which gives the one-cycle done pulse.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One Booth iteration. The pair {Q0,Q_1} selects subtract, add or keep
   // for the accumulator, then {A,Q,Q_1} is shifted right arithmetically.
   // A is one bit wider than the operands so that subtracting the most
   // negative multiplicand cannot overflow. In the unsigned build Q has a
   // spare top bit; signed operations skip it so their shift path and the
   // product bit positions are identical to the signed-only build.
   always_comb begin
      a_sum = a;
      case ({q[0], q_1})
         2'b10:   a_sum = a - m;
         2'b01:   a_sum = a + m;
         default: a_sum = a;
      endcase
      a_next = {a_sum[N], a_sum[N:1]};
`ifdef BOOTH_UNSIGNED_EN
      if (uns_r) begin
         q_next = {a_sum[0], q[QW-1:1]};
         result = {a_next[N-2:0], q_next};
      end else begin
         q_next = {1'b0, a_sum[0], q[N-1:1]};
         result = {a_next[N-1:0], q_next[N-1:0]};
      end
`else
      q_next = {a_sum[0], q[N-1:1]};
      result = {a_next[N-1:0], q_next};
`endif
   end

   // Datapath registers. Operands are captured only on the edge that leaves
   // IDLE, so later operand changes have no effect. The product register is
   // written only on the last RUN iteration (the RUN->DONE edge) and is
   // otherwise held until the next completion or a reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a       <= '0;
         m       <= '0;
         q       <= '0;
         q_1     <= 1'b0;
         cnt     <= '0;
         product <= '0;
`ifdef BOOTH_UNSIGNED_EN
         uns_r   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a   <= '0;
                  q_1 <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
                  uns_r <= uns;
                  if (uns) begin
                     m   <= {1'b0, multiplicand};
                     q   <= {1'b0, multiplier};
                     cnt <= CW'(N + 1);
                  end else begin
                     m   <= {multiplicand[N-1], multiplicand};
                     q   <= {multiplier[N-1], multiplier};
                     cnt <= CW'(N);
                  end
`else
                  m   <= {multiplicand[N-1], multiplicand};
                  q   <= multiplier;
                  cnt <= CW'(N);
`endif
               end
            end
            RUN: begin
               a   <= a_next;
               q   <= q_next;
               q_1 <= q[0];
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  product <= result;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
//   Self-checking bench for booth_mult_seq with N = 4. Expected products come
//   from plain integer multiplication of the operands; expected handshake
//   timing comes from the documented latency (busy for one cycle per
//   iteration, then a single done cycle).
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

   localparam int N = 4;

   logic           clk;
   logic           reset;
   logic           start;
`ifdef BOOTH_UNSIGNED_EN
   logic           uns;
`endif
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int checkCount = 0;
   int passCount  = 0;

   booth_mult_seq #(.N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
`ifdef BOOTH_UNSIGNED_EN
      .uns          (uns),
`endif
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference product: ordinary multiplication on the integer values the
   // operands represent, truncated to the 2N-bit product width.
   function automatic logic [2*N-1:0] modelProduct(input logic [N-1:0] x,
                                                   input logic [N-1:0] y,
                                                   input bit u);
      longint px;
      longint py;
      if (u) begin
         px = longint'(x);
         py = longint'(y);
      end else begin
         px = longint'($signed(x));
         py = longint'($signed(y));
      end
      return (2*N)'(px * py);
   endfunction

   // One comparison: counts it, counts a pass, or reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drives one request in an IDLE cycle and follows it to completion,
   // checking busy/done each cycle and the product afterwards. With
   // holdStart, start stays high and the operands keep changing during RUN.
   task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y,
                                input bit u, input bit holdStart,
                                input string tag);
      logic [2*N-1:0] expProd;
      int             iters;
      expProd = modelProduct(x, y, u);
      iters   = u ? N + 1 : N;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = x;
      multiplier   = y;
`ifdef BOOTH_UNSIGNED_EN
      uns          = u;
`endif
      for (int k = 0; k < iters; k++) begin
         @(posedge clk);
         #1;
         if (!holdStart) start = 1'b0;
         multiplicand = N'($urandom);
         multiplier   = N'($urandom);
`ifdef BOOTH_UNSIGNED_EN
         uns          = 1'($urandom);
`endif
         checkOutput({tag, " busy"}, 32'(busy), 32'd1);
         checkOutput({tag, " done-early"}, 32'(done), 32'd0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput({tag, " done"}, 32'(done), 32'd1);
      checkOutput({tag, " busy-in-done"}, 32'(busy), 32'd0);
      checkOutput({tag, " product"}, 32'(product), 32'(expProd));
      @(posedge clk);
      #1;
      checkOutput({tag, " done-single"}, 32'(done), 32'd0);
      checkOutput({tag, " product-hold"}, 32'(product), 32'(expProd));
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
`ifdef BOOTH_UNSIGNED_EN
      uns          = 1'b0;
`endif

      // Reset state
      #12;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset product", 32'(product), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed products, including the most negative operands
      applyStimulus(4'd3, 4'hE, 1'b0, 1'b0, "3*-2");
      applyStimulus(4'h8, 4'h8, 1'b0, 1'b0, "-8*-8");
      applyStimulus(4'd7, 4'h8, 1'b0, 1'b0, "7*-8");
      applyStimulus(4'd0, 4'd5, 1'b0, 1'b0, "0*5");
      applyStimulus(4'h8, 4'd7, 1'b0, 1'b0, "-8*7");

      // start held high through RUN with changing operands
      applyStimulus(4'd5, 4'hD, 1'b0, 1'b1, "hold 5*-3");

      // Reset in the middle of an operation
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 4'd6;
      multiplier   = 4'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midrun reset busy", 32'(busy), 32'd0);
      checkOutput("midrun reset done", 32'(done), 32'd0);
      checkOutput("midrun reset product", 32'(product), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         checkOutput("after reset no done", 32'(done), 32'd0);
      end
      checkOutput("after reset product", 32'(product), 32'd0);
      applyStimulus(4'd6, 4'd5, 1'b0, 1'b0, "post-reset 6*5");

      // Back-to-back operations
      applyStimulus(4'd2, 4'd3, 1'b0, 1'b0, "b2b 2*3");
      applyStimulus(4'hF, 4'hF, 1'b0, 1'b0, "b2b -1*-1");

`ifdef BOOTH_UNSIGNED_EN
      applyStimulus(4'hF, 4'hF, 1'b1, 1'b0, "uns 15*15");
      applyStimulus(4'hF, 4'hF, 1'b0, 1'b0, "sgn -1*-1");
      applyStimulus(4'h8, 4'h9, 1'b1, 1'b0, "uns 8*9");
`endif

      // Random operands
      for (int r = 0; r < 20; r++) begin
         logic [N-1:0] rx;
         logic [N-1:0] ry;
         bit           ru;
         rx = N'($urandom);
         ry = N'($urandom);
`ifdef BOOTH_UNSIGNED_EN
         ru = 1'($urandom);
`else
         ru = 1'b0;
`endif
         applyStimulus(rx, ry, ru, 1'b0, "random");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
